mult_operand_sequencer: RTL and testbench

Front-end stage for the 8x8 Wallace-tree multiplier on the DE-series board. Captures two 8-bit operands from one 8-switch bank using a conditioned push-button: first press loads the multiplicand, second press loads the multiplier. It then presents both operands to the combinational multiplier, waits a fixed settle time, and registers the 16-bit product for the hex-display drivers. This frees `SW[15:8]` and makes every displayed result a registered, glitch-free value.

---
 rtl/mult_operand_sequencer_pkg.sv | 14 +
 rtl/mult_operand_sequencer_if.sv | 22 ++
 rtl/mult_operand_sequencer_btn_conditioner.sv | 49 ++++
 rtl/mult_operand_sequencer.sv | 105 ++++++++++
 tb/tb_mult_operand_sequencer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mult_operand_sequencer_pkg.sv
// Shared types and widths for the multiplier operand sequencer.
package mult_seq_pkg;

    localparam int OPERAND_W = 8;
    localparam int PRODUCT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_Q = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } seq_state_e;

endpackage

// File: rtl/mult_operand_sequencer_if.sv
// Operand/product bus between the sequencer and the combinational multiplier.
interface mult_operand_sequencer_if;
    import mult_seq_pkg::*;

    logic [OPERAND_W-1:0] m_out;
    logic [OPERAND_W-1:0] q_out;
    logic                 op_valid;
    logic [PRODUCT_W-1:0] product_in;
    logic [PRODUCT_W-1:0] result;
    logic                 result_valid;

    modport master (
        output m_out, q_out, op_valid, result, result_valid,
        input  product_in
    );

    modport slave (
        input  m_out, q_out, op_valid, result, result_valid,
        output product_in
    );

endinterface

// File: rtl/mult_operand_sequencer_btn_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, level debounce, rising-edge pulse.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic ev_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             level_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The level flips on the DEBOUNCE_CYCLES-th consecutive cycle of disagreement.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign ev_o = level_q & ~level_prev_q;

endmodule

// File: rtl/mult_operand_sequencer.sv
// Two-press operand capture, settle wait and registered product capture for the multiplier.
module mult_operand_sequencer
    import mult_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SETTLE_CYCLES   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [OPERAND_W-1:0]  sw_data,
    input  logic                  load_btn,
    input  logic                  clear_btn,
    mult_operand_sequencer_if.master bus,
    output logic [1:0]            state_o
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic load_ev, clear_ev;

    seq_state_e           state_q;
    logic [OPERAND_W-1:0] m_q, q_q;
    logic [PRODUCT_W-1:0] result_q;
    logic                 op_valid_q, result_valid_q;
    logic [SET_W-1:0]     settle_q;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_cond (
        .clk   (clk),
        .reset (reset),
        .btn_i (load_btn),
        .ev_o  (load_ev)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_cond (
        .clk   (clk),
        .reset (reset),
        .btn_i (clear_btn),
        .ev_o  (clear_ev)
    );

    // Clear takes priority over everything, so a simultaneous load is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            m_q            <= '0;
            q_q            <= '0;
            result_q       <= '0;
            op_valid_q     <= 1'b0;
            result_valid_q <= 1'b0;
            settle_q       <= '0;
        end else if (clear_ev) begin
            state_q        <= IDLE;
            m_q            <= '0;
            q_q            <= '0;
            result_q       <= '0;
            op_valid_q     <= 1'b0;
            result_valid_q <= 1'b0;
            settle_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_ev) begin
                        m_q     <= sw_data;
                        state_q <= WAIT_Q;
                    end
                end
                WAIT_Q: begin
                    if (load_ev) begin
                        q_q        <= sw_data;
                        op_valid_q <= 1'b1;
                        settle_q   <= '0;
                        state_q    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                        result_q       <= bus.product_in;
                        result_valid_q <= 1'b1;
                        state_q        <= DONE;
                    end else begin
                        settle_q <= settle_q + SET_W'(1);
                    end
                end
                DONE: begin
                    // The old result stays on the display until the next pair completes.
                    if (load_ev) begin
                        m_q            <= sw_data;
                        op_valid_q     <= 1'b0;
                        result_valid_q <= 1'b0;
                        state_q        <= WAIT_Q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.m_out        = m_q;
    assign bus.q_out        = q_q;
    assign bus.op_valid     = op_valid_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Directed bench for mult_operand_sequencer with a behavioural multiplier on product_in.
module tb_mult_operand_sequencer;
    import mult_seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw_data;
    logic       load_btn, clear_btn;
    logic [1:0] state;

    logic [7:0] sw2;
    logic       load2;
    logic       clear2;
    logic [1:0] state2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int opvRise, rvRise, t0, tRv;

    mult_operand_sequencer_if bus ();
    mult_operand_sequencer_if bus2 ();

    assign bus.product_in  = 16'(bus.m_out) * 16'(bus.q_out);
    assign bus2.product_in = 16'(bus2.m_out) * 16'(bus2.q_out);

    mult_operand_sequencer #(.DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_data   (sw_data),
        .load_btn  (load_btn),
        .clear_btn (clear_btn),
        .bus       (bus),
        .state_o   (state)
    );

    // A long settle window so a second load press can land inside SETTLE.
    mult_operand_sequencer #(.DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(24)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .sw_data   (sw2),
        .load_btn  (load2),
        .clear_btn (clear2),
        .bus       (bus2),
        .state_o   (state2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Holds the buttons for 10 cycles then releases for 10, noting op_valid/result_valid rises.
    task automatic applyStimulus(input logic [7:0] data, input logic doLoad, input logic doClear,
                                 output int opvAt, output int rvAt);
        logic prevOpv, prevRv;
        opvAt = -1;
        rvAt  = -1;
        @(negedge clk);
        sw_data   = data;
        load_btn  = doLoad;
        clear_btn = doClear;
        prevOpv   = bus.op_valid;
        prevRv    = bus.result_valid;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 9) begin
                load_btn  = 1'b0;
                clear_btn = 1'b0;
            end
            if (!prevOpv && bus.op_valid && opvAt < 0) opvAt = cyc;
            if (!prevRv && bus.result_valid && rvAt < 0) rvAt = cyc;
            prevOpv = bus.op_valid;
            prevRv  = bus.result_valid;
        end
    endtask

    initial begin
        reset     = 1'b1;
        sw_data   = 8'h00;
        load_btn  = 1'b0;
        clear_btn = 1'b0;
        sw2       = 8'h00;
        load2     = 1'b0;
        clear2    = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset_m", bus.m_out, 8'h00);
        checkOutput("reset_q", bus.q_out, 8'h00);
        checkOutput("reset_result", bus.result, 16'h0000);
        checkOutput("reset_opv", bus.op_valid, 1'b0);
        checkOutput("reset_rv", bus.result_valid, 1'b0);
        checkOutput("reset_state", state, 2'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // 0x0F * 0x0F
        applyStimulus(8'h0F, 1'b1, 1'b0, opvRise, rvRise);
        checkOutput("p1_m", bus.m_out, 8'h0F);
        checkOutput("p1_state", state, 2'd1);
        checkOutput("p1_opv", bus.op_valid, 1'b0);
        applyStimulus(8'h0F, 1'b1, 1'b0, opvRise, rvRise);
        checkOutput("p2_q", bus.q_out, 8'h0F);
        checkOutput("p2_result", bus.result, 16'h00E1);
        checkOutput("p2_rv", bus.result_valid, 1'b1);
        checkOutput("p2_opv", bus.op_valid, 1'b1);
        checkOutput("p2_state", state, 2'd3);
        checkOutput("p2_settle_lat", 32'(rvRise - opvRise), 32'd4);

        // 0xFF * 0xFF, then a third press restarts from DONE
        applyStimulus(8'hFF, 1'b1, 1'b0, opvRise, rvRise);
        checkOutput("ff_m", bus.m_out, 8'hFF);
        checkOutput("ff_state_waitq", state, 2'd1);
        checkOutput("ff_rv_low", bus.result_valid, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b0, opvRise, rvRise);
        checkOutput("ff_result", bus.result, 16'hFE01);
        checkOutput("ff_state_done", state, 2'd3);
        applyStimulus(8'h03, 1'b1, 1'b0, opvRise, rvRise);
        checkOutput("third_m", bus.m_out, 8'h03);
        checkOutput("third_rv", bus.result_valid, 1'b0);
        checkOutput("third_opv", bus.op_valid, 1'b0);
        checkOutput("third_state", state, 2'd1);
        checkOutput("third_result_kept", bus.result, 16'hFE01);

        // Clear alone from WAIT_Q
        applyStimulus(8'h55, 1'b0, 1'b1, opvRise, rvRise);
        checkOutput("clr_state", state, 2'd0);
        checkOutput("clr_m", bus.m_out, 8'h00);
        checkOutput("clr_result", bus.result, 16'h0000);

        // Bouncy press: 1,1,0,0,1,1 then held 6 more cycles gives a single event
        @(negedge clk);
        sw_data = 8'hA5;
        for (int i = 0; i < 24; i++) begin
            load_btn = (i < 2 || (i >= 4 && i < 12)) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        checkOutput("bounce_state", state, 2'd1);
        checkOutput("bounce_m", bus.m_out, 8'hA5);
        checkOutput("bounce_q", bus.q_out, 8'h00);
        checkOutput("bounce_opv", bus.op_valid, 1'b0);

        // Clear and load in the same cycle from WAIT_Q with m_out=0x12
        applyStimulus(8'h00, 1'b0, 1'b1, opvRise, rvRise);
        applyStimulus(8'h12, 1'b1, 1'b0, opvRise, rvRise);
        checkOutput("pre_both_m", bus.m_out, 8'h12);
        checkOutput("pre_both_state", state, 2'd1);
        applyStimulus(8'h34, 1'b1, 1'b1, opvRise, rvRise);
        checkOutput("both_state", state, 2'd0);
        checkOutput("both_m", bus.m_out, 8'h00);
        checkOutput("both_q", bus.q_out, 8'h00);
        checkOutput("both_result", bus.result, 16'h0000);
        checkOutput("both_opv", bus.op_valid, 1'b0);
        checkOutput("both_rv", bus.result_valid, 1'b0);

        // Asynchronous reset two cycles into SETTLE with operands 0x07, 0x09
        applyStimulus(8'h07, 1'b1, 1'b0, opvRise, rvRise);
        @(negedge clk);
        sw_data  = 8'h09;
        load_btn = 1'b1;
        for (int i = 0; i < 20 && !bus.op_valid; i++) @(negedge clk);
        checkOutput("rst_opv_seen", bus.op_valid, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("rst_in_settle", state, 2'd2);
        reset = 1'b1;
        #1;
        checkOutput("rst_async_state", state, 2'd0);
        checkOutput("rst_async_m", bus.m_out, 8'h00);
        checkOutput("rst_async_q", bus.q_out, 8'h00);
        checkOutput("rst_async_opv", bus.op_valid, 1'b0);
        checkOutput("rst_async_result", bus.result, 16'h0000);
        load_btn = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        checkOutput("rst_after_result", bus.result, 16'h0000);
        checkOutput("rst_after_rv", bus.result_valid, 1'b0);
        checkOutput("rst_after_state", state, 2'd0);

        // Load pressed during SETTLE on the long-settle instance is ignored
        @(negedge clk);
        sw2   = 8'h07;
        load2 = 1'b1;
        repeat (10) @(negedge clk);
        load2 = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("s2_m", bus2.m_out, 8'h07);
        sw2   = 8'h09;
        load2 = 1'b1;
        for (int i = 0; i < 20 && !bus2.op_valid; i++) @(negedge clk);
        checkOutput("s2_opv_seen", bus2.op_valid, 1'b1);
        t0 = cyc;
        @(negedge clk);
        load2 = 1'b0;
        sw2   = 8'hEE;
        repeat (8) @(negedge clk);
        load2 = 1'b1;
        repeat (9) @(negedge clk);
        load2 = 1'b0;
        checkOutput("s2_ignored_state", state2, 2'd2);
        checkOutput("s2_ignored_m", bus2.m_out, 8'h07);
        checkOutput("s2_ignored_q", bus2.q_out, 8'h09);
        tRv = -1;
        for (int i = 0; i < 30 && tRv < 0; i++) begin
            @(negedge clk);
            if (bus2.result_valid) tRv = cyc;
        end
        checkOutput("s2_settle_lat", 32'(tRv - t0), 32'd24);
        checkOutput("s2_result", bus2.result, 16'h003F);
        checkOutput("s2_state", state2, 2'd3);
        checkOutput("s2_m_kept", bus2.m_out, 8'h07);
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
